div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 106 ++++++++++
 tb/tb_div_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider (DIV/DIVU) with annul and EX-stage stall request.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations via the DIVZERO state.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ON      = 2'd1,
`ifdef DIV_ZERO_FAST_EN
        S_DIVZERO = 2'd3,
`endif
        S_END     = 2'd2
    } state_t;

    state_t state, state_nx;
    logic [DATA_W-1:0] rem_q, dvd_q, dsr_q;
    logic neg_quo, neg_rem;
    logic [CNT_W-1:0] cnt;
    logic start_ok, last, qbit;
    logic [DATA_W:0] shifted, trial;
    logic [DATA_W-1:0] rem_nx, quo_nx, quo_fin, rem_fin, a_mag, b_mag;

    assign start_ok = start_i & ~annul_i;
    assign last     = cnt == CNT_W'(DATA_W - 1);
    assign a_mag    = (signed_div_i & opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign b_mag    = (signed_div_i & opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    // One restoring step: bring in the next dividend bit, keep the subtraction if it did not borrow.
    // The dividend register shifts left and collects quotient bits in its LSB.
    assign shifted  = {rem_q, dvd_q[DATA_W-1]};
    assign trial    = shifted - {1'b0, dsr_q};
    assign qbit     = ~trial[DATA_W];
    assign rem_nx   = qbit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    assign quo_nx   = (dvd_q << 1) | DATA_W'(qbit);
    assign quo_fin  = neg_quo ? -quo_nx : quo_nx;
    assign rem_fin  = neg_rem ? -rem_nx : rem_nx;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; annul only matters while a divide is in flight
    always_comb begin
        state_nx = state;
        case (state)
`ifdef DIV_ZERO_FAST_EN
            S_IDLE:    state_nx = start_ok ? ((opdata2_i == '0) ? S_DIVZERO : S_ON) : S_IDLE;
            S_DIVZERO: state_nx = annul_i ? S_IDLE : S_END;
`else
            S_IDLE:    state_nx = start_ok ? S_ON : S_IDLE;
`endif
            S_ON:      state_nx = annul_i ? S_IDLE : (last ? S_END : S_ON);
            S_END:     state_nx = start_i ? S_END : S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state; stall until the result is presented
    always_comb begin
        ready_o    = state == S_END;
        stallreq_o = start_i & ~ready_o;
    end

    // Operand capture and the per-cycle shift-subtract datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            cnt     <= '0;
        end else if (state == S_IDLE && start_ok) begin
            rem_q   <= '0;
            dvd_q   <= a_mag;
            dsr_q   <= b_mag;
            neg_quo <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem <= signed_div_i & opdata1_i[DATA_W-1];
            cnt     <= '0;
        end else if (state == S_ON && !annul_i) begin
            rem_q   <= rem_nx;
            dvd_q   <= quo_nx;
            cnt     <= cnt + 1'b1;
        end
    end

    // Result register: written on the final step, held in END, cleared whenever heading to IDLE
    always_ff @(posedge clk) begin
        if (rst || state_nx == S_IDLE) result_o <= '0;
        else if (state == S_ON && last) result_o <= {rem_fin, quo_fin};
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit (DATA_W=32).
module tb_div_unit;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst, start, annul, sgn;
    logic [W-1:0] a, b;
    logic [2*W-1:0] result;
    logic ready, stall;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .signed_div_i(sgn),
        .opdata1_i(a), .opdata2_i(b), .result_o(result), .ready_o(ready), .stallreq_o(stall)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1; start = 0; annul = 0; sgn = 0; a = 0; b = 0;
        tick; tick;
        checks++; if (ready !== 1'b0 || result !== '0) begin errors++; $display("FAIL reset_outputs: ready=%b result=%h expected ready=0 result=0", ready, result); end
        start = 1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_start: stall=%b expected 1", stall); end
        tick;
        checks++; if (ready !== 1'b0 || result !== '0) begin errors++; $display("FAIL reset_hold_start: ready=%b result=%h expected 0/0", ready, result); end
        start = 0; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: stall=%b expected 0", stall); end
        rst = 0;
        tick;
    endtask

    task automatic run_div(input string name, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [2*W-1:0] exp, input int lat);
        int c;
        int stall_bad;
        sgn = s; a = x; b = y; start = 1; #1;
        c = 0; stall_bad = 0;
        while (ready !== 1'b1 && c < lat + 5) begin
            if (stall !== 1'b1) stall_bad++;
            tick;
            c++;
            if (c == 1) begin a = ~x; b = x ^ y ^ 32'h5; sgn = ~s; end
        end
        checks++; if (c !== lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, c, lat); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL %s stall_busy: %0d low cycles expected 0", name, stall_bad); end
        checks++; if (result !== exp) begin errors++; $display("FAIL %s result: got %h expected %h", name, result, exp); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s stall_ready: got %b expected 0", name, stall); end
        tick;
        checks++; if (ready !== 1'b1 || result !== exp) begin errors++; $display("FAIL %s hold: ready=%b result=%h expected 1/%h", name, ready, result, exp); end
        start = 0; tick;
        checks++; if (ready !== 1'b0 || result !== '0 || stall !== 1'b0) begin errors++; $display("FAIL %s release: ready=%b result=%h stall=%b expected 0/0/0", name, ready, result, stall); end
    endtask

    task automatic test_unsigned;
        run_div("udiv_100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
        run_div("udiv_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 33);
    endtask

    task automatic test_signed;
        run_div("sdiv_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
        run_div("sdiv_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
        run_div("sdiv_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33);
        run_div("sdiv_100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, {32'h2, 32'hFFFFFFF2}, 33);
    endtask

    task automatic test_divzero;
`ifdef DIV_ZERO_FAST_EN
        run_div("udiv_7_0", 1'b0, 32'd7, 32'd0, '0, 2);
        run_div("sdiv_m7_0", 1'b1, 32'hFFFFFFF9, 32'd0, '0, 2);
`else
        run_div("udiv_7_0", 1'b0, 32'd7, 32'd0, {32'h7, 32'hFFFFFFFF}, 33);
        run_div("sdiv_m7_0", 1'b1, 32'hFFFFFFF9, 32'd0, {32'hFFFFFFF9, 32'h1}, 33);
`endif
    endtask

    task automatic test_annul;
        int c;
        int early;
        sgn = 0; a = 32'd1000; b = 32'd3; start = 1; #1;
        c = 0; early = 0;
        while (c < 10) begin tick; c++; if (ready !== 1'b0) early++; end
        annul = 1;
        tick; c++;
        annul = 0; start = 0; #1;
        checks++; if (ready !== 1'b0 || result !== '0 || stall !== 1'b0) begin errors++; $display("FAIL annul_idle: ready=%b result=%h stall=%b expected 0/0/0", ready, result, stall); end
        tick; c++;
        a = 32'd100; b = 32'd7; start = 1; #1;
        while (ready !== 1'b1 && c < 60) begin tick; c++; if (c < 45 && ready !== 1'b0) early++; end
        checks++; if (c !== 45) begin errors++; $display("FAIL annul_restart_latency: got %0d expected 45", c); end
        checks++; if (early !== 0) begin errors++; $display("FAIL annul_no_ready: %0d early ready cycles expected 0", early); end
        checks++; if (result !== {32'h2, 32'hE}) begin errors++; $display("FAIL annul_restart_result: got %h expected %h", result, {32'h2, 32'hE}); end
        start = 0; tick;
        annul = 1; a = 32'd100; b = 32'd7; start = 1; #1;
        c = 0;
        tick; c++;
        annul = 0;
        while (ready !== 1'b1 && c < 60) begin tick; c++; end
        checks++; if (c !== 34) begin errors++; $display("FAIL annul_blocks_start: latency %0d expected 34", c); end
        annul = 1;
        tick;
        checks++; if (ready !== 1'b1 || result !== {32'h2, 32'hE}) begin errors++; $display("FAIL annul_in_end: ready=%b result=%h expected 1/%h", ready, result, {32'h2, 32'hE}); end
        annul = 0; start = 0; tick;
        checks++; if (ready !== 1'b0 || result !== '0) begin errors++; $display("FAIL annul_end_release: ready=%b result=%h expected 0/0", ready, result); end
    endtask

    task automatic test_reset_mid;
        int c;
        sgn = 0; a = 32'd100; b = 32'd7; start = 1; #1;
        c = 0;
        while (c < 20) begin tick; c++; end
        rst = 1;
        tick; c++;
        checks++; if (ready !== 1'b0 || result !== '0) begin errors++; $display("FAIL reset_mid: ready=%b result=%h expected 0/0", ready, result); end
        rst = 0;
        while (ready !== 1'b1 && c < 70) begin tick; c++; end
        checks++; if (c !== 54) begin errors++; $display("FAIL reset_mid_restart_latency: got %0d expected 54", c); end
        checks++; if (result !== {32'h2, 32'hE}) begin errors++; $display("FAIL reset_mid_result: got %h expected %h", result, {32'h2, 32'hE}); end
        start = 0; tick;
        checks++; if (ready !== 1'b0 || result !== '0 || stall !== 1'b0) begin errors++; $display("FAIL reset_mid_release: ready=%b result=%h stall=%b expected 0/0/0", ready, result, stall); end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_divzero;
        test_annul;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
